// File: rtl/clip_queue.sv
// Frames AHB words into packed triangles, clips them against signed bounds,
// and queues accepted triangles in a show-ahead FIFO for the rasteriser.
module clip_queue #(
    parameter int                         COORD_W     = 16,
    parameter int                         COLOR_W     = 8,
    parameter int                         DEPTH       = 4,
    parameter logic signed [COORD_W-1:0]  XMIN        = COORD_W'(0),
    parameter logic signed [COORD_W-1:0]  XMAX        = COORD_W'(639),
    parameter logic signed [COORD_W-1:0]  YMIN        = COORD_W'(0),
    parameter logic signed [COORD_W-1:0]  YMAX        = COORD_W'(479),
    parameter logic signed [COORD_W-1:0]  ZMIN        = COORD_W'(0),
    parameter logic signed [COORD_W-1:0]  ZMAX        = COORD_W'(32767),
    parameter bit                         DROP_OOB    = 1'b1,
    parameter logic [31:0]                FRAME_START = 32'd0,
    parameter logic [31:0]                FRAME_END   = 32'd1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  ahb_buffer,
    input  logic                         ahb_data_available,
    output logic                         ahb_user_read_buffer,
    input  logic                         triangle_read,
    output logic [9*COORD_W-1:0]         triangle_vertices_out,
    output logic [3*COLOR_W-1:0]         triangle_color_out,
    output logic                         triangle_oob,
    output logic                         triangle_ready,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         frame_active,
    output logic                         frame_done,
    output logic [15:0]                  drop_count
);

    localparam int VBITS   = 9 * COORD_W;
    localparam int CBITS   = 3 * COLOR_W;
    localparam int TBITS   = VBITS + CBITS;
    localparam int WORDS   = (TBITS + 31) / 32;
    localparam int SBITS   = 32 * WORDS;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WCNT_W  = $clog2(WORDS) + 1;
    localparam int ENTRY_W = TBITS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_COLLECT,
        S_CHECK
    } state_t;

    state_t              state_reg;
    logic [WCNT_W-1:0]   word_cnt_reg;
    logic [31:0]         word_reg [WORDS];
    logic                frame_active_reg;
    logic                frame_done_reg;
    logic [15:0]         drop_count_reg;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    logic                take;
    logic                store_first;
    logic                store_coll;
    logic [WORDS-1:0]    word_we;
    logic [SBITS-1:0]    stream;
    logic [8:0]          coord_oob;
    logic                oob;
    logic                drop_now;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                push;
    logic [ENTRY_W-1:0]  head;

    // Words are taken in every state except CHECK; reset masks the strobe.
    assign take        = !rst && ahb_data_available && (state_reg != S_CHECK);
    assign store_first = take && (state_reg == S_FRAME)
                         && (ahb_buffer != FRAME_END) && (ahb_buffer != FRAME_START);
    assign store_coll  = take && (state_reg == S_COLLECT);

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            if (gi == 0) begin : g_first
                assign word_we[gi] = store_first || (store_coll && word_cnt_reg == '0);
            end else begin : g_rest
                assign word_we[gi] = store_coll && (word_cnt_reg == WCNT_W'(gi));
            end
            assign stream[gi*32 +: 32] = word_reg[gi];
        end

        if (SBITS > TBITS) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^stream[SBITS-1:TBITS];
        end

        // Coordinate gi belongs to axis gi%3 (x, y, z) of vertex gi/3.
        for (gi = 0; gi < 9; gi++) begin : g_bound
            localparam int AXIS = gi % 3;
            localparam logic signed [COORD_W-1:0] LO =
                (AXIS == 0) ? XMIN : (AXIS == 1) ? YMIN : ZMIN;
            localparam logic signed [COORD_W-1:0] HI =
                (AXIS == 0) ? XMAX : (AXIS == 1) ? YMAX : ZMAX;
            logic signed [COORD_W-1:0] coord;
            assign coord         = stream[gi*COORD_W +: COORD_W];
            assign coord_oob[gi] = (coord < LO) || (coord > HI);
        end
    endgenerate

    assign oob        = |coord_oob;
    assign drop_now   = oob && DROP_OOB;
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(DEPTH));
    assign pop        = triangle_read && !fifo_empty;
    assign push       = (state_reg == S_CHECK) && !drop_now && (!fifo_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                word_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (word_we[i]) begin
                    word_reg[i] <= ahb_buffer;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            word_cnt_reg     <= '0;
            frame_active_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
            drop_count_reg   <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (take && ahb_buffer == FRAME_START) begin
                        state_reg        <= S_FRAME;
                        frame_active_reg <= 1'b1;
                        drop_count_reg   <= '0;
                    end
                end
                S_FRAME: begin
                    if (take) begin
                        if (ahb_buffer == FRAME_END) begin
                            state_reg        <= S_IDLE;
                            frame_active_reg <= 1'b0;
                            frame_done_reg   <= 1'b1;
                        end else if (ahb_buffer != FRAME_START) begin
                            word_cnt_reg <= WCNT_W'(1);
                            state_reg    <= (WORDS == 1) ? S_CHECK : S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (take) begin
                        word_cnt_reg <= word_cnt_reg + WCNT_W'(1);
                        if (word_cnt_reg == WCNT_W'(WORDS - 1)) begin
                            state_reg <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (drop_now) begin
                        if (drop_count_reg != 16'hFFFF) begin
                            drop_count_reg <= drop_count_reg + 16'd1;
                        end
                        state_reg <= S_FRAME;
                    end else if (push) begin
                        state_reg <= S_FRAME;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO masks its outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {oob, stream[TBITS-1:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign head                  = mem[rd_ptr_reg];
    assign triangle_vertices_out = fifo_empty ? '0 : head[VBITS-1:0];
    assign triangle_color_out    = fifo_empty ? '0 : head[TBITS-1:VBITS];
    assign triangle_oob          = fifo_empty ? 1'b0 : head[TBITS];
    assign triangle_ready        = !fifo_empty;
    assign fifo_count            = count_reg;
    assign ahb_user_read_buffer  = take;
    assign frame_active          = frame_active_reg;
    assign frame_done            = frame_done_reg;
    assign drop_count            = drop_count_reg;

endmodule

// File: tb/tb_clip_queue.sv
// Directed bench for clip_queue: three instances (full-range bounds, default
// bounds with drop, default bounds with tagging) driven one at a time.
module tb_clip_queue;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic          rst;
    logic [31:0]   buf_s   [3];
    logic          avail_s [3];
    logic          rd_s    [3];
    logic          ura_s   [3];
    logic [143:0]  vert_s  [3];
    logic [23:0]   col_s   [3];
    logic          oob_s   [3];
    logic          ready_s [3];
    logic [2:0]    cnt_s   [3];
    logic          fa_s    [3];
    logic          fd_s    [3];
    logic [15:0]   drop_s  [3];

    int total = 0;
    int bad   = 0;

    localparam logic [143:0] PAT_V = 144'h3210_FFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
    localparam logic [23:0]  PAT_C = 24'hBB_DD_FF;
    logic [31:0] pat [6] = '{32'h33221100, 32'h77665544, 32'hBBAA9988,
                             32'hFFEEDDCC, 32'hDDFF3210, 32'hCCCCCCBB};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam bit FULL = (gi == 0);
            localparam logic signed [15:0] MINV = 16'sh8000;
            localparam logic signed [15:0] MAXV = 16'sh7FFF;
            clip_queue #(
                .COORD_W(16), .COLOR_W(8), .DEPTH(4),
                .XMIN(FULL ? MINV : 16'sd0), .XMAX(FULL ? MAXV : 16'sd639),
                .YMIN(FULL ? MINV : 16'sd0), .YMAX(FULL ? MAXV : 16'sd479),
                .ZMIN(FULL ? MINV : 16'sd0), .ZMAX(FULL ? MAXV : 16'sd32767),
                .DROP_OOB(gi != 2),
                .FRAME_START(32'd0), .FRAME_END(32'd1)
            ) dut (
                .clk(tb_clk),
                .rst(rst),
                .ahb_buffer(buf_s[gi]),
                .ahb_data_available(avail_s[gi]),
                .ahb_user_read_buffer(ura_s[gi]),
                .triangle_read(rd_s[gi]),
                .triangle_vertices_out(vert_s[gi]),
                .triangle_color_out(col_s[gi]),
                .triangle_oob(oob_s[gi]),
                .triangle_ready(ready_s[gi]),
                .fifo_count(cnt_s[gi]),
                .frame_active(fa_s[gi]),
                .frame_done(fd_s[gi]),
                .drop_count(drop_s[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; presents one word, checks it is taken, returns at posedge+1.
    task automatic send_word(input int d, input logic [31:0] w);
        buf_s[d]   = w;
        avail_s[d] = 1'b1;
        #1;
        chk("consume", ura_s[d], 1'b1);
        @(posedge tb_clk); #1;
        avail_s[d] = 1'b0;
    endtask

    task automatic idle();
        @(posedge tb_clk); #1;
    endtask

    function automatic logic [31:0] tw(input int k, input int j);
        return {8'(k + 1), 8'(j), 16'hC3C3};
    endfunction

    function automatic logic [143:0] exp_vert(input int k);
        logic [31:0] w0, w1, w2, w3, w4;
        w0 = tw(k, 0); w1 = tw(k, 1); w2 = tw(k, 2); w3 = tw(k, 3); w4 = tw(k, 4);
        return {w4[15:0], w3, w2, w1, w0};
    endfunction

    function automatic logic [23:0] exp_col(input int k);
        logic [31:0] w4, w5;
        w4 = tw(k, 4); w5 = tw(k, 5);
        return {w5[7:0], w4[31:16]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            buf_s[i] = '0; avail_s[i] = 1'b0; rd_s[i] = 1'b0;
        end
        repeat (3) @(posedge tb_clk);
        #1;
        chk("rst ready", ready_s[0], 1'b0);
        chk("rst count", cnt_s[0], 3'd0);
        chk("rst vert", vert_s[0], 144'd0);
        chk("rst frame_active", fa_s[0], 1'b0);
        chk("rst drop", drop_s[0], 16'd0);
        chk("rst ura", ura_s[0], 1'b0);
        rst = 1'b0;

        // Full-range bounds: triangle assembles and appears two cycles after its last word.
        send_word(0, 32'd0);
        chk("t1 frame_active", fa_s[0], 1'b1);
        for (int j = 0; j < 6; j++) send_word(0, pat[j]);
        chk("t1 ready in check", ready_s[0], 1'b0);
        idle();
        chk("t1 ready", ready_s[0], 1'b1);
        chk("t1 vert", vert_s[0], PAT_V);
        chk("t1 color", col_s[0], PAT_C);
        chk("t1 oob", oob_s[0], 1'b0);
        chk("t1 count", cnt_s[0], 3'd1);
        rd_s[0] = 1'b1; idle(); rd_s[0] = 1'b0;
        chk("t1 popped ready", ready_s[0], 1'b0);
        chk("t1 popped vert", vert_s[0], 144'd0);

        // Default bounds: p.y = 0x3322 is outside 0..479.
        for (int d = 1; d < 3; d++) begin
            send_word(d, 32'd0);
            for (int j = 0; j < 6; j++) send_word(d, pat[j]);
            idle();
        end
        chk("drop count", drop_s[1], 16'd1);
        chk("drop ready", ready_s[1], 1'b0);
        chk("tag ready", ready_s[2], 1'b1);
        chk("tag oob", oob_s[2], 1'b1);
        chk("tag vert", vert_s[2], PAT_V);
        chk("tag drop", drop_s[2], 16'd0);
        send_word(1, 32'd1);
        chk("end done", fd_s[1], 1'b1);
        chk("end active", fa_s[1], 1'b0);
        idle();
        chk("end done low", fd_s[1], 1'b0);
        send_word(1, 32'hDEADBEEF);
        chk("idle junk active", fa_s[1], 1'b0);
        chk("idle junk drop", drop_s[1], 16'd1);
        send_word(1, 32'd0);
        chk("restart drop cleared", drop_s[1], 16'd0);
        chk("restart active", fa_s[1], 1'b1);

        // Fill the FIFO, then stall the fifth triangle in CHECK.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 6; j++) send_word(0, tw(k, j));
            idle();
        end
        chk("full count", cnt_s[0], 3'd4);
        chk("full head", vert_s[0], exp_vert(0));
        for (int j = 0; j < 6; j++) send_word(0, tw(4, j));
        buf_s[0] = 32'd1; avail_s[0] = 1'b1;
        #1;
        chk("stall ura", ura_s[0], 1'b0);
        @(posedge tb_clk); #1;
        chk("stall ura held", ura_s[0], 1'b0);
        chk("stall count", cnt_s[0], 3'd4);
        rd_s[0] = 1'b1;
        @(posedge tb_clk); #1;
        rd_s[0] = 1'b0;
        #1;
        chk("pushpop count", cnt_s[0], 3'd4);
        chk("pushpop head", vert_s[0], exp_vert(1));
        chk("pushpop color", col_s[0], exp_col(1));
        chk("resume ura", ura_s[0], 1'b1);
        @(posedge tb_clk); #1;
        avail_s[0] = 1'b0;
        chk("frame_done pulse", fd_s[0], 1'b1);
        chk("frame_active off", fa_s[0], 1'b0);
        idle();
        chk("frame_done one cycle", fd_s[0], 1'b0);
        for (int k = 1; k < 3; k++) begin
            chk("drain head", vert_s[0], exp_vert(k));
            rd_s[0] = 1'b1; idle(); rd_s[0] = 1'b0;
        end
        chk("drain count", cnt_s[0], 3'd2);
        chk("drain head tail", vert_s[0], exp_vert(3));
        send_word(0, 32'h5555AAAA);
        chk("idle discard", fa_s[0], 1'b0);

        // Reset mid-triangle with two entries queued.
        send_word(0, 32'd0);
        for (int j = 0; j < 3; j++) send_word(0, tw(9, j));
        rst = 1'b1;
        #1;
        chk("arst ready", ready_s[0], 1'b0);
        chk("arst count", cnt_s[0], 3'd0);
        chk("arst vert", vert_s[0], 144'd0);
        chk("arst color", col_s[0], 24'd0);
        chk("arst oob", oob_s[0], 1'b0);
        chk("arst active", fa_s[0], 1'b0);
        chk("arst done", fd_s[0], 1'b0);
        chk("arst ura", ura_s[0], 1'b0);
        @(posedge tb_clk); #1;
        rst = 1'b0;
        send_word(0, 32'd0);
        for (int j = 0; j < 6; j++) send_word(0, tw(5, j));
        idle();
        chk("post ready", ready_s[0], 1'b1);
        chk("post count", cnt_s[0], 3'd1);
        chk("post vert", vert_s[0], exp_vert(5));
        chk("post color", col_s[0], exp_col(5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
